// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input  busy, done, sum, cout);
  modport slave  (input  start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_full_adder.sv
// 1-bit full-adder cell: two half adders, carries merged with an OR.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: sequences one full-adder cell over WIDTH bits, LSB first,
// carry held in a flop; result presented with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q;
  logic             fa_s, fa_c;

  serial_full_adder u_fa (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sum fills from the MSB end so after WIDTH shifts it lands in natural order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sh_a   <= bus.a;
          sh_b   <= bus.b;
          carry  <= 1'b0;
          cnt    <= '0;
          sum_q  <= '0;
          cout_q <= 1'b0;
        end
        RUN: begin
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) cout_q <= fa_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench: model pushes expected results on accepted starts, monitor checks.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state (written only by the model process)
  int         cyc = 0;
  int         busy_until = -1;
  int         wp = 0;
  int         exp_cyc [256];
  logic [W:0] exp_res [256];

  // Monitor state (written only by the monitor process)
  int         rp = 0;
  logic [W:0] last_res = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
  endfunction

  // Model: an op is accepted on any edge once the previous op's DONE edge has passed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_until = -1;
    end else begin
      cyc++;
      if (bus.start && cyc > busy_until + 1) begin
        exp_cyc[wp % 256] = cyc + W;
        exp_res[wp % 256] = {1'b0, bus.a} + {1'b0, bus.b};
        wp++;
        busy_until = cyc + W;
      end
    end
  end

  // Monitor: sample away from the rising edge, and just after any reset assertion.
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_result", 64'({bus.cout, bus.sum}), 64'd0);
      rp = wp;
      last_res = '0;
    end else begin
      logic exp_done;
      exp_done = (rp != wp) && (exp_cyc[rp % 256] == cyc);
      chk("busy", 64'(bus.busy), 64'(cyc <= busy_until));
      chk("done", 64'(bus.done), 64'(exp_done));
      if (exp_done) begin
        chk("result", 64'({bus.cout, bus.sum}), 64'(exp_res[rp % 256]));
        last_res = exp_res[rp % 256];
        rp++;
      end else if (cyc > busy_until) begin
        chk("hold", 64'({bus.cout, bus.sum}), 64'(last_res));
      end
    end
  end

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int gap);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = ta; bus.b = tb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    op(8'h03, 8'h05, 12);
    op(8'hFF, 8'h01, 12);
    op(8'hAA, 8'h55, 12);

    // Starts during RUN and during DONE must be ignored
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    repeat (3) @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);

    // Back-to-back: start held, operands churn every cycle
    @(posedge clk); #1;
    bus.start = 1'b1;
    repeat (40) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);

    // Random ops with random gaps (some land while busy)
    repeat (20) op(W'($urandom), W'($urandom), $urandom_range(0, 12));
    repeat (12) @(posedge clk);

    // Reset in the middle of RUN
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h33;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    op(8'h7F, 8'h01, 14);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single 1-bit full-adder cell, built from two half-adder cells, across the bits of two WIDTH-bit operands, LSB first, one bit per clock. A requester issues a start pulse. The block latches the operands, runs WIDTH add cycles while holding the carry in a flop, then presents the sum and carry-out with a one-cycle done pulse. It sits between any requester that needs an occasional multi-bit add and the shared single-bit adder datapath, trading latency for area.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; state leaves reset on the first clk edge after deassertion.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the edge that accepts start.
- b  input  WIDTH  operand B; sampled on the edge that accepts start.
- busy  output  1  high in RUN and DONE; low in IDLE.
- done  output  1  single-cycle pulse; high exactly while in DONE.
- sum  output  WIDTH  result; stable from DONE until the next accepted start.
- cout  output  1  carry-out of the MSB; same validity as sum.

## Operation
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, bit counter=0, operand shift registers=0.
- FSM states:
  - IDLE → RUN on start=1. That edge loads shA←a, shB←b, carry←0, cnt←0, and clears sum and cout to 0.
  - RUN: each edge computes {c,s} = shA[0]+shB[0]+carry through the full-adder cell.
    - Right-shift s into sum MSB; shift shA and shB right by 1; carry←c; cnt←cnt+1.
    - When cnt==WIDTH-1 on that edge: go to DONE and load cout←c.
  - DONE → IDLE unconditionally on the next edge.
- After WIDTH shifts, sum holds (a+b) mod 2^WIDTH in natural bit order. cout equals bit WIDTH of the (WIDTH+1)-bit true sum.
- start is ignored in RUN and DONE: no queuing and no operand capture. Changes on a or b after acceptance have no effect.
- cnt width is $clog2(WIDTH). It never wraps within an operation because exit happens at WIDTH-1.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values above. The partial sum is discarded and no done is pulsed.
- No abort input. No arithmetic overflow flag beyond cout.

## Timing
- Edge E0 accepts start. RUN covers edges E1..E(WIDTH); the E(WIDTH) edge enters DONE. done=1 for the cycle after E(WIDTH). The E(WIDTH+1) edge returns to IDLE.
- Latency from the accepting edge to done high is WIDTH clock edges. Done is visible in the cycle following the WIDTH-th RUN edge.
- Minimum start-to-start spacing is WIDTH+2 cycles. With start held high continuously, a new operation is accepted on the first IDLE edge, i.e. every WIDTH+2 cycles.
- busy rises in the cycle after the accepting edge and falls in the cycle after DONE.
- sum and cout are registered outputs with no combinational path from inputs. The adder cell is purely combinational between flops.

## Structure
- Package serial_add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t
  - localparam default WIDTH
- Sub-module serial_full_adder: ports a, b, cin, s, cout.
  - Built from two half-adder cells plus an OR for the carry.
  - Instantiated once in serial_add_ctrl.
  - Kept separate so it is unit-testable exhaustively (8 vectors).
- Everything else (FSM, counter, shift registers, result register) lives in serial_add_ctrl.

## Test plan
- Reset check: after reset release with start=0 for 5 cycles → busy=0, done=0, sum=0x00, cout=0.
- Basic add (WIDTH=8): a=0x03, b=0x05, one-cycle start → done pulses exactly 8 edges after the accepting edge; sum=0x08, cout=0; sum holds until the next start.
- Carry ripple/overflow: a=0xFF, b=0x01 → sum=0x00, cout=1. Also a=0xAA, b=0x55 → sum=0xFF, cout=0.
- Start during busy: a=0x10, b=0x20 accepted; pulse start with a=0x77, b=0x77 at RUN cycle 3 and again in DONE → only one done pulse; result sum=0x30, cout=0.
- Back-to-back: start held high, operands changed each time IDLE is reached → done every 10 cycles; each result matches the operands sampled in the preceding IDLE.
- Reset mid-operation: assert rst_n=0 at RUN cycle 4 → outputs return to reset values in the same cycle, with no done pulse. After release, a fresh 0x7F+0x01 gives sum=0x80, cout=0.
